sram_ctrl: RTL and testbench

- Single-port SRAM access sequencer that sits directly upstream of the tristate bus buffer.
- Accepts one read or write request at a time over a valid/ready handshake.
- Generates the SRAM strobes (CE_N, OE_N, WE_N, UB_N, LB_N) and the address, drives tristate_output_enable and Data_write, and captures Data_read.
- Timing accounts for the buffer's one-cycle registered write path and one-cycle registered read path.

---
 rtl/sram_ctrl_if.sv | 25 ++
 rtl/sram_ctrl.sv | 140 ++++++++++++++
 tb/tb_sram_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// Request/response handshake between a client and the SRAM sequencer.
// The master issues requests; the slave (sram_ctrl) accepts them and returns completions.
interface sram_ctrl_if #(
   parameter int N  = 16,
   parameter int AW = 20
);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [N-1:0]  req_wdata;
   logic [1:0]    req_be;
   logic          rsp_valid;
   logic [N-1:0]  rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_ctrl.sv
// Single-port SRAM sequencer feeding a registered tristate buffer; write 3+WAIT_CYCLES, read 2+WAIT_CYCLES cycles to rsp_valid.
// Backpressure: req_ready is high only in IDLE, so a request presented while busy waits until the controller returns there.
module sram_ctrl #(
   parameter int N           = 16,
   parameter int AW          = 20,
   parameter int WAIT_CYCLES = 2
) (
   input  logic          Clk,
   input  logic          Reset_n,
   sram_ctrl_if.slave    req_if,
   output logic [AW-1:0] ADDR,
   output logic          CE_N,
   output logic          OE_N,
   output logic          WE_N,
   output logic          UB_N,
   output logic          LB_N,
   output logic          tristate_output_enable,
   output logic [N-1:0]  Data_write,
   input  logic [N-1:0]  Data_read
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] W_SETUP  = 3'd1;
   localparam logic [2:0] W_PULSE  = 3'd2;
   localparam logic [2:0] W_HOLD   = 3'd3;
   localparam logic [2:0] R_ACCESS = 3'd4;
   localparam logic [2:0] R_SAMPLE = 3'd5;
   localparam logic [2:0] RESP     = 3'd6;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   logic [2:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [N-1:0]  wdata_q, wdata_d;
   logic [1:0]    be_q, be_d;
   logic [N-1:0]  rdata_q, rdata_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (req_if.req_valid) begin
               addr_d  = req_if.req_addr;
               wdata_d = req_if.req_wdata;
               be_d    = req_if.req_be;
               if (req_if.req_we) begin
                  state_d = W_SETUP;
               end else begin
                  state_d = R_ACCESS;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         W_SETUP: begin
            state_d = W_PULSE;
            cnt_d   = WAIT_LOAD;
         end
         W_PULSE: begin
            if (cnt_q == 4'd0) state_d = W_HOLD;
            else               cnt_d   = cnt_q - 4'd1;
         end
         W_HOLD: state_d = RESP;
         R_ACCESS: begin
            if (cnt_q == 4'd0) state_d = R_SAMPLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         R_SAMPLE: begin
            // Data_read already carries the buffer's sample from the last access cycle
            rdata_d = Data_read;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
      end
   end

   // Every output is a pure decode of registered state, so reset drops the strobes at once
   always_comb begin
      CE_N                   = 1'b1;
      OE_N                   = 1'b1;
      WE_N                   = 1'b1;
      UB_N                   = 1'b1;
      LB_N                   = 1'b1;
      tristate_output_enable = 1'b0;
      case (state_q)
         W_SETUP: CE_N = 1'b0;
         W_PULSE: begin
            CE_N                   = 1'b0;
            WE_N                   = 1'b0;
            UB_N                   = ~be_q[1];
            LB_N                   = ~be_q[0];
            tristate_output_enable = 1'b1;
         end
         W_HOLD: begin
            CE_N                   = 1'b0;
            UB_N                   = ~be_q[1];
            LB_N                   = ~be_q[0];
            tristate_output_enable = 1'b1;
         end
         R_ACCESS, R_SAMPLE: begin
            CE_N = 1'b0;
            OE_N = 1'b0;
            UB_N = 1'b0;
            LB_N = 1'b0;
         end
         default: ;
      endcase
   end

   assign ADDR             = addr_q;
   assign Data_write       = wdata_q;
   assign req_if.req_ready = (state_q == IDLE);
   assign req_if.rsp_valid = (state_q == RESP);
   assign req_if.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: a vector table of read/write transactions checked cycle by cycle,
// plus hand sequences for back-to-back requests and reset during a write pulse.
module tb_sram_ctrl;
   localparam int N  = 16;
   localparam int AW = 20;
   localparam int W  = 2;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic [AW-1:0] ADDR;
   logic          CE_N, OE_N, WE_N, UB_N, LB_N;
   logic          tristate_output_enable;
   logic [N-1:0]  Data_write;
   logic [N-1:0]  Data_read = '0;

   always #5 Clk = ~Clk;

   sram_ctrl_if #(.N(N), .AW(AW)) bus ();

   sram_ctrl #(.N(N), .AW(AW), .WAIT_CYCLES(W)) dut (
      .Clk                    (Clk),
      .Reset_n                (Reset_n),
      .req_if                 (bus),
      .ADDR                   (ADDR),
      .CE_N                   (CE_N),
      .OE_N                   (OE_N),
      .WE_N                   (WE_N),
      .UB_N                   (UB_N),
      .LB_N                   (LB_N),
      .tristate_output_enable (tristate_output_enable),
      .Data_write             (Data_write),
      .Data_read              (Data_read)
   );

   // Registered bus buffer plus SRAM; read data is only valid after W cycles of OE_N low.
   logic [N-1:0] mem [256] = '{default: '0};
   logic [N-1:0] wr_buf = '0;
   int           oe_run = 0;

   always @(posedge Clk) begin
      wr_buf <= Data_write;
      if (!CE_N && !OE_N) begin
         Data_read <= (oe_run >= W - 1) ? mem[ADDR[7:0]] : 16'h0BAD;
         oe_run    <= oe_run + 1;
      end else begin
         oe_run <= 0;
      end
      if (!CE_N && !WE_N && tristate_output_enable) begin
         if (!UB_N) mem[ADDR[7:0]][15:8] <= wr_buf[15:8];
         if (!LB_N) mem[ADDR[7:0]][7:0]  <= wr_buf[7:0];
      end
   end

   // Bus contention / turnaround watch
   int since_ten  = 99;
   int turn_viol  = 0;
   always @(negedge Clk) begin
      if (tristate_output_enable) since_ten = 0;
      else if (since_ten < 99)    since_ten = since_ten + 1;
      if (!OE_N && tristate_output_enable) turn_viol = turn_viol + 1;
      if (!OE_N && since_ten < 3)          turn_viol = turn_viol + 1;
   end

   int n_cmp = 0;
   int n_err = 0;
   logic [N-1:0] held_rdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pins();
      return {CE_N, OE_N, WE_N, UB_N, LB_N, tristate_output_enable, bus.req_ready, bus.rsp_valid};
   endfunction

   // {CE_N,OE_N,WE_N,UB_N,LB_N,enable,req_ready,rsp_valid} for cycle c after acceptance
   function automatic logic [7:0] exp_pins(input logic we, input int c, input logic [1:0] be);
      if (we) begin
         if (c == 1)          return 8'b0111_1000;
         else if (c <= 1 + W) return {3'b010, ~be[1], ~be[0], 3'b100};
         else if (c == 2 + W) return 8'b0111_1100;
         else                 return 8'b1111_1001;
      end else begin
         if (c <= 1 + W) return 8'b0010_0000;
         else            return 8'b1111_1001;
      end
   endfunction

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [N-1:0]  wdata;
      logic [1:0]    be;
      logic [N-1:0]  exp_rdata;
   } vec_t;

   task automatic run_vec(input vec_t v);
      int         last;
      logic [7:0] mask;
      bus.req_valid = 1'b1;
      bus.req_we    = v.we;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      bus.req_be    = v.be;
      @(posedge Clk); #1;
      bus.req_valid = 1'b0;
      last = v.we ? 3 + W : 2 + W;
      for (int c = 1; c <= last; c++) begin
         mask = (v.we && (c == 1 || c == 2 + W)) ? 8'hE7 : 8'hFF;
         chk($sformatf("pins %s c%0d", v.we ? "wr" : "rd", c), 32'(pins() & mask),
             32'(exp_pins(v.we, c, v.be) & mask));
         if (c == 1) chk("addr", 32'(ADDR), 32'(v.addr));
         if (v.we && c == 1) chk("data_write", 32'(Data_write), 32'(v.wdata));
         if (c == last) begin
            if (!v.we) held_rdata = v.exp_rdata;
            chk(v.we ? "rdata_kept_on_write" : "rdata", 32'(bus.rsp_rdata), 32'(held_rdata));
         end
         @(posedge Clk); #1;
      end
      chk("idle_after_resp", 32'(pins()), 32'(8'b1111_1010));
      chk("rdata_hold", 32'(bus.rsp_rdata), 32'(held_rdata));
   endtask

   vec_t vt[12];
   int   rsp_seen;

   initial begin
      vt[0]  = '{1'b1, 20'h00012, 16'hBEEF, 2'b11, 16'h0000};
      vt[1]  = '{1'b0, 20'h00012, 16'h0000, 2'b00, 16'hBEEF};
      vt[2]  = '{1'b1, 20'h00012, 16'h12AB, 2'b01, 16'h0000};
      vt[3]  = '{1'b0, 20'h00012, 16'h0000, 2'b00, 16'hBEAB};
      vt[4]  = '{1'b1, 20'h00034, 16'hA5A5, 2'b00, 16'h0000};
      vt[5]  = '{1'b0, 20'h00034, 16'h0000, 2'b00, 16'h0000};
      vt[6]  = '{1'b1, 20'h00034, 16'h77CC, 2'b10, 16'h0000};
      vt[7]  = '{1'b0, 20'h00034, 16'h0000, 2'b00, 16'h7700};
      vt[8]  = '{1'b1, 20'hABC56, 16'h5A5A, 2'b11, 16'h0000};
      vt[9]  = '{1'b0, 20'hABC56, 16'h0000, 2'b00, 16'h5A5A};
      vt[10] = '{1'b1, 20'h000A0, 16'h4242, 2'b11, 16'h0000};
      vt[11] = '{1'b0, 20'h000A0, 16'h0000, 2'b00, 16'h4242};

      // Request offered during reset must not be taken
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 20'h00077;
      bus.req_wdata = 16'h9999;
      bus.req_be    = 2'b11;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset_pins", 32'(pins()), 32'(8'b1111_1010));
      bus.req_valid = 1'b0;
      #2 Reset_n = 1'b1;
      repeat (5) @(posedge Clk);
      #1;
      chk("idle_pins", 32'(pins()), 32'(8'b1111_1010));
      chk("idle_addr", 32'(ADDR), 32'h0);
      chk("idle_data_write", 32'(Data_write), 32'h0);
      chk("idle_rdata", 32'(bus.rsp_rdata), 32'h0);

      for (int i = 0; i < 10; i++) run_vec(vt[i]);

      // req_valid held high: write then read, read taken only in the IDLE after RESP
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 20'h00078;
      bus.req_wdata = 16'h1357;
      bus.req_be    = 2'b11;
      @(posedge Clk); #1;
      chk("b2b c1 ready", 32'(bus.req_ready), 32'h0);
      bus.req_we = 1'b0;
      for (int c = 2; c <= 10; c++) begin
         @(posedge Clk); #1;
         chk($sformatf("b2b c%0d", c), 32'({bus.req_ready, bus.rsp_valid, OE_N}),
             32'({c == 6, c == 5 || c == 10, !(c >= 7 && c <= 9)}));
         if (c == 7) bus.req_valid = 1'b0;
      end
      chk("b2b rdata", 32'(bus.rsp_rdata), 32'h1357);
      held_rdata = 16'h1357;
      @(posedge Clk); #1;

      // Reset in the second W_PULSE cycle
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 20'h00090;
      bus.req_wdata = 16'hCAFE;
      bus.req_be    = 2'b11;
      @(posedge Clk); #1;
      bus.req_valid = 1'b0;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      chk("pulse2 pins", 32'({WE_N, tristate_output_enable}), 32'b01);
      #2 Reset_n = 1'b0;
      #1;
      chk("rst pins", 32'(pins()), 32'(8'b1111_1010));
      chk("rst rdata", 32'(bus.rsp_rdata), 32'h0);
      held_rdata = '0;
      #2 Reset_n = 1'b1;
      rsp_seen = 0;
      repeat (6) begin
         @(posedge Clk); #1;
         if (bus.rsp_valid) rsp_seen++;
      end
      chk("no_rsp_after_reset", 32'(rsp_seen), 32'h0);
      run_vec(vt[10]);
      run_vec(vt[11]);

      chk("turnaround", 32'(turn_viol), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
